// File: rtl/span_cme.sv
// span_cme - SPAN-style margin engine for a single commodity.
//
// The host writes the price, five contract-month positions and the risk
// parameters into a 29-entry register file. Every accepted write restarts
// the engine. The engine snapshots the net position and the price scan
// range, then scores seven price moves k = -3..+3, one per cycle. A final
// cycle adds the spread and spot charges. The scanning risk and the total
// margin are then published.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   chipselect     bus select, qualifies write and read
//   write / read   bus strobes
//   offset         register address 0..31
//   writeData      write data
//   readData       registered read data (1-cycle latency)
//   PriceScanRange (P*S)/100 from the current registers, combinational
module span_cme (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  offset,
    input  logic [15:0] writeData,
    output logic [15:0] readData,
    output logic [15:0] PriceScanRange
);
    localparam int NREG  = 29;
    localparam int NSCEN = 7;
    // Step 0 is the snapshot cycle. Steps 1..NSCEN are the scenarios.
    localparam logic [2:0] LAST_STEP = 3'(NSCEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Clamp a non-negative margin quantity into the 16-bit result field.
    function automatic logic [15:0] sat16(input logic [39:0] v);
        logic [15:0] r;
        if (v > 40'h00_0000_FFFF) begin
            r = 16'hFFFF;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    logic [15:0]        regs_r [NREG];
    state_t             state_r, state_s;
    logic [2:0]         step_r, step_s;
    logic signed [18:0] n_r;
    logic [15:0]        psr_r;
    logic signed [35:0] max_r;
    logic [15:0]        scan_r, total_r;
    logic               valid_r;

    logic               wr_s, busy_s, kneg_s;
    logic [15:0]        psr_s, rd_mux_s;
    logic signed [18:0] n_s, long_s, short_s, m_s;
    logic [18:0]        min_s;
    logic [16:0]        q1_abs_s;
    logic [2:0]         kmag_s;
    logic [17:0]        mag_s;
    logic signed [35:0] loss_s;
    logic [39:0]        total_s;

    assign wr_s   = chipselect & write & (offset <= 5'd28);
    assign busy_s = (state_r != IDLE);
    assign psr_s  = 16'(({16'd0, regs_r[0]} * {16'd0, regs_r[6]}) / 32'd100);
    assign PriceScanRange = psr_s;

    // Net position, plus the long and short totals used for the spread charge.
    always_comb begin
        n_s     = 19'sd0;
        long_s  = 19'sd0;
        short_s = 19'sd0;
        for (int i = 1; i <= 5; i++) begin
            n_s = n_s + 19'($signed(regs_r[i]));
            if (regs_r[i][15]) begin
                short_s = short_s - 19'($signed(regs_r[i]));
            end else begin
                long_s = long_s + 19'($signed(regs_r[i]));
            end
        end
    end

    assign min_s    = (long_s < short_s) ? 19'(long_s) : 19'(short_s);
    assign q1_abs_s = regs_r[1][15] ? (17'd0 - {1'b1, regs_r[1]}) : {1'b0, regs_r[1]};

    // Scenario step s maps to move k = s - 4. The move is |k|/3 of the scan range, truncated.
    assign kneg_s = (step_r < 3'd4);
    assign kmag_s = kneg_s ? (3'd4 - step_r) : (step_r - 3'd4);
    assign mag_s  = 18'(({2'b00, psr_r} * {15'd0, kmag_s}) / 18'd3);
    assign m_s    = kneg_s ? -$signed({1'b0, mag_s}) : $signed({1'b0, mag_s});
    assign loss_s = -(36'(n_r) * 36'(m_s));

    assign total_s = 40'($unsigned(max_r))
                   + 40'(min_s) * 40'(regs_r[7])
                   + 40'(q1_abs_s) * 40'(regs_r[8]);

    // Next-state logic. An accepted write restarts the engine from any state.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        if (wr_s) begin
            state_s = SCAN;
            step_s  = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                SCAN: begin
                    if (step_r == LAST_STEP) begin
                        state_s = FINAL;
                        step_s  = 3'd0;
                    end else begin
                        step_s = step_r + 3'd1;
                    end
                end
                FINAL: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                    step_s  = 3'd0;
                end
            endcase
        end
    end

    // FSM state and scenario step registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            step_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
        end
    end

    // Engine datapath: snapshot, running worst-case loss, final results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_r     <= 19'sd0;
            psr_r   <= 16'd0;
            max_r   <= 36'sd0;
            scan_r  <= 16'd0;
            total_r <= 16'd0;
            valid_r <= 1'b0;
        end else if (wr_s) begin
            valid_r <= 1'b0;
            max_r   <= 36'sd0;
        end else begin
            case (state_r)
                SCAN: begin
                    if (step_r == 3'd0) begin
                        n_r   <= n_s;
                        psr_r <= psr_s;
                        max_r <= 36'sd0;
                    end else if (loss_s > max_r) begin
                        max_r <= loss_s;
                    end
                end
                FINAL: begin
                    scan_r  <= sat16(40'($unsigned(max_r)));
                    total_r <= sat16(total_s);
                    valid_r <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Read multiplexer: register file, results and status.
    always_comb begin
        rd_mux_s = 16'd0;
        case (offset)
            5'd29:   rd_mux_s = total_r;
            5'd30:   rd_mux_s = scan_r;
            5'd31:   rd_mux_s = {14'd0, busy_s, valid_r};
            default: rd_mux_s = regs_r[offset];
        endcase
    end

    // Host register file and registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 16'd0;
            end
            readData <= 16'd0;
        end else begin
            if (wr_s) begin
                regs_r[offset] <= writeData;
            end
            if (chipselect && read) begin
                readData <= rd_mux_s;
            end
        end
    end
endmodule

// File: tb/tb_span_cme.sv
module tb_span_cme;
    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [4:0]  offset;
    logic [15:0] writeData;
    logic [15:0] readData;
    logic [15:0] PriceScanRange;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [15:0] m_regs [29];

    typedef struct {
        logic [15:0] p, q1, q2, q3, q4, q5, s, r, t;
        int exp_psr, exp_scan, exp_total;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    span_cme dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .offset(offset), .writeData(writeData),
        .readData(readData), .PriceScanRange(PriceScanRange)
    );

    task automatic check(input string name, input longint got, input longint exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] off, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; offset = off; writeData = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
        if (off <= 5'd28) m_regs[off] = d;
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; offset = off;
        @(posedge clk);
        #1;
        d = readData;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model, computed directly from the margin rules.
    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint sat(input longint v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic longint model_psr();
        return ((longint'(m_regs[0]) * longint'(m_regs[6])) / 100) % 65536;
    endfunction

    function automatic longint model_worst();
        longint psr = model_psr();
        longint n = 0;
        longint best = 0;
        for (int i = 1; i <= 5; i++) n += longint'($signed(m_regs[i]));
        for (int k = -3; k <= 3; k++) begin
            longint mag = (psr * labs(k)) / 3;
            longint m = (k < 0) ? -mag : mag;
            longint loss = -n * m;
            if (loss > best) best = loss;
        end
        return best;
    endfunction

    function automatic longint model_scan();
        return sat(model_worst());
    endfunction

    function automatic longint model_total();
        longint l = 0, sh = 0;
        for (int i = 1; i <= 5; i++) begin
            longint q = longint'($signed(m_regs[i]));
            if (q > 0) l += q; else sh += -q;
        end
        return sat(model_worst() + ((l < sh) ? l : sh) * longint'(m_regs[7])
                   + labs(longint'($signed(m_regs[1]))) * longint'(m_regs[8]));
    endfunction

    initial begin
        logic [15:0] d;
        logic [15:0] v;

        tbl[0] = '{16'd300, 16'd30, 16'd30, 16'(-10), 16'(-10), 16'(-20), 16'd5, 16'd0, 16'd0, 15, 300, 300};
        tbl[1] = '{16'd300, 16'd10, 16'd15, 16'(-10), 16'(-20), 16'(-20), 16'd10, 16'd4, 16'd2, 30, 750, 870};
        tbl[2] = '{16'd96, 16'd10, 16'd15, 16'(-5), 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0};
        tbl[3] = '{16'd65535, 16'd32767, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd0, 16'd0, 65535, 65535, 65535};
        tbl[4] = '{16'd1000, 16'(-100), 16'(-50), 16'd0, 16'd0, 16'd0, 16'd30, 16'd7, 16'd3, 300, 45000, 45300};
        tbl[5] = '{16'd200, 16'd5, 16'(-5), 16'd0, 16'd0, 16'd0, 16'd50, 16'd9, 16'd11, 100, 0, 100};
        tbl[6] = '{16'd100, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 1, 3, 3};
        tbl[7] = '{16'd199, 16'd0, 16'd0, 16'd0, 16'd0, 16'(-2), 16'd1, 16'd0, 16'd0, 1, 2, 2};

        for (int i = 0; i < 29; i++) m_regs[i] = 16'd0;
        reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        offset = 5'd0; writeData = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readData, 0);
        check("reset_psr", PriceScanRange, 0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(5'd31, d); check("reset_status", d, 0);
        bus_read(5'd30, d); check("reset_scan", d, 0);
        bus_read(5'd29, d); check("reset_total", d, 0);

        // Table-driven margin vectors
        for (int i = 0; i < 8; i++) begin
            bus_write(5'd0, tbl[i].p);
            bus_write(5'd1, tbl[i].q1);
            bus_write(5'd2, tbl[i].q2);
            bus_write(5'd3, tbl[i].q3);
            bus_write(5'd4, tbl[i].q4);
            bus_write(5'd5, tbl[i].q5);
            bus_write(5'd6, tbl[i].s);
            bus_write(5'd7, tbl[i].r);
            bus_write(5'd8, tbl[i].t);
            idle(10);
            check($sformatf("tbl%0d_psr", i), PriceScanRange, tbl[i].exp_psr);
            bus_read(5'd31, d); check($sformatf("tbl%0d_status", i), d, 1);
            bus_read(5'd30, d); check($sformatf("tbl%0d_scan", i), d, tbl[i].exp_scan);
            bus_read(5'd29, d); check($sformatf("tbl%0d_total", i), d, tbl[i].exp_total);
        end

        // Write during SCAN restarts; exact 9-edge latency from the last write
        bus_write(5'd0, 16'd400);
        bus_write(5'd1, 16'd20);
        bus_write(5'd6, 16'd20);
        idle(2);
        bus_write(5'd0, 16'd800);
        for (int j = 1; j <= 10; j++) begin
            bus_read(5'd31, d);
            check($sformatf("restart_status_e%0d", j), d, (j <= 9) ? 2 : 1);
        end
        bus_read(5'd30, d); check("restart_scan", d, model_scan());
        bus_read(5'd29, d); check("restart_total", d, model_total());

        // Register readback
        for (int i = 0; i < 29; i++) bus_write(5'(i), 16'(16'h1357 + i * 613));
        idle(10);
        for (int i = 0; i < 29; i++) begin
            bus_read(5'(i), d);
            check($sformatf("readback_%0d", i), d, m_regs[i]);
        end
        bus_write(5'd30, 16'h1234);
        bus_read(5'd31, d); check("wr30_status", d, 1);
        bus_read(5'd30, d); check("wr30_scan", d, model_scan());
        bus_read(5'd29, d); check("wr30_total", d, model_total());

        // Simultaneous read and write to the same register returns the old value
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b1; offset = 5'd9; writeData = 16'hBEEF;
        @(posedge clk);
        #1;
        check("rw_same_old", readData, m_regs[9]);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        m_regs[9] = 16'hBEEF;
        bus_read(5'd9, d); check("rw_same_new", d, 16'hBEEF);

        // Randomized stimulus against the reference model
        for (int it = 0; it < 25; it++) begin
            for (int r = 0; r <= 8; r++) begin
                case ($urandom_range(0, 2))
                    0: v = 16'($urandom_range(0, 200));
                    1: v = 16'($urandom);
                    default: v = 16'(-$urandom_range(0, 300));
                endcase
                if (r == 0 || r >= 6) v = (v[15]) ? 16'($urandom_range(0, 1000)) : v;
                bus_write(5'(r), v);
            end
            idle(10);
            check($sformatf("rand%0d_psr", it), PriceScanRange, model_psr());
            bus_read(5'd30, d); check($sformatf("rand%0d_scan", it), d, model_scan());
            bus_read(5'd29, d); check($sformatf("rand%0d_total", it), d, model_total());
        end

        // Reset asserted mid-SCAN
        bus_write(5'd0, 16'd500);
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_readdata", readData, 0);
        check("midreset_psr", PriceScanRange, 0);
        for (int i = 0; i < 29; i++) m_regs[i] = 16'd0;
        @(negedge clk);
        reset = 1'b1;
        bus_read(5'd31, d); check("midreset_status", d, 0);
        bus_read(5'd30, d); check("midreset_scan", d, 0);
        bus_read(5'd29, d); check("midreset_total", d, 0);
        bus_read(5'd0, d);  check("midreset_reg0", d, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
